// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake, operands and result of the bit-serial adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell plus registered carry
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_if.slave      bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_s;
    logic             w_c1;
    logic [WIDTH-1:0] w_acc_next;

    // the single full-adder cell on the LSBs of the shift registers and the carry
    always_comb begin
        w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
        w_c1       = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
        w_acc_next = {w_s, r_acc[WIDTH-1:1]};
    end

    // load operands on start, shift one bit per cycle, publish result on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    r_a_sh  <= bus.a;
                    r_b_sh  <= bus.b;
                    r_carry <= bus.cin;
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
            end else begin
                r_acc   <= w_acc_next;
                r_a_sh  <= r_a_sh >> 1;
                r_b_sh  <= r_b_sh >> 1;
                r_carry <= w_c1;
                r_cnt   <= r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_sum   <= w_acc_next;
                    r_cout  <= w_c1;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against a+b+cin
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [8:0] prev = 9'h000;

    serial_adder_if #(.WIDTH(8)) bus ();

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // one addition; inj >= 0 raises a stray start on that busy cycle
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c, input int inj);
        logic [8:0] exp;
        int lat;
        int nbusy;
        bit hold_ok;
        exp = 9'(a) + 9'(b) + 9'(c);
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        nbusy = 0;
        hold_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 20) begin
            nbusy += int'(bus.busy);
            if ({bus.cout, bus.sum} !== prev) hold_ok = 1'b0;
            if (lat == inj) begin
                bus.start = 1'b1;
                bus.a = 8'hFF;
                bus.b = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("latency", lat, 8);
        check("busy_cycles", nbusy, 8);
        check("result_hold", 32'(hold_ok), 1);
        check("sum", 32'(bus.sum), 32'(exp[7:0]));
        check("cout", 32'(bus.cout), 32'(exp[8]));
        check("busy_at_done", 32'(bus.busy), 0);
        prev = exp;
    endtask

    // idle cycles, counting any done pulse
    task automatic idle_dones(input int n, output int dones);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
    endtask

    initial begin
        int d;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        #12;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_sum", 32'(bus.sum), 0);
        check("rst_cout", 32'(bus.cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_dones(4, d);
        check("idle_dones", d, 0);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_sum", 32'(bus.sum), 0);

        run_add(8'h5A, 8'h33, 1'b0, -1);
        idle_dones(1, d);
        check("done_pulse", d, 0);
        run_add(8'hFF, 8'h01, 1'b0, -1);
        run_add(8'hFF, 8'h00, 1'b1, -1);
        run_add(8'hFF, 8'hFF, 1'b1, -1);
        idle_dones(2, d);

        run_add(8'h10, 8'h20, 1'b0, 2);
        idle_dones(12, d);
        check("stray_start_dones", d, 0);

        run_add(8'h80, 8'h80, 1'b0, -1);
        run_add(8'h01, 8'h02, 1'b0, -1);
        idle_dones(1, d);

        bus.a = 8'h55;
        bus.b = 8'hAA;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_sum", 32'(bus.sum), 0);
        check("abort_cout", 32'(bus.cout), 0);
        prev = 9'h000;
        @(negedge clk);
        rst_n = 1'b1;
        idle_dones(12, d);
        check("abort_no_done", d, 0);
        run_add(8'h01, 8'h01, 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            run_add(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
            if ($urandom_range(0, 1) == 1) idle_dones(int'($urandom_range(1, 3)), d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that produces a full-width sum one bit per clock from a single `full_adder` cell plus a registered carry. It sits downstream of the combinational adder cells (`half_adder`/`full_adder`): it consumes the cell's sum and carry outputs every cycle and turns them into a registered multi-bit result with a start/done handshake. It is the low-area alternative to a ripple-carry chain.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled on a rising edge while not busy.
- `a`  input  WIDTH  addend, sampled with `start`.
- `b`  input  WIDTH  addend, sampled with `start`.
- `cin`  input  1  carry-in, sampled with `start`.
- `busy`  output  1  high while an addition is in progress.
- `done`  output  1  one-cycle pulse; the result is valid from this cycle on.
- `sum`  output  WIDTH  result register; holds its value until the next completion.
- `cout`  output  1  final carry-out register, held like `sum`.

## Operation
- Internal registers:
  - `a_sh` and `b_sh` are WIDTH-bit shift registers.
  - `acc` is the WIDTH-bit partial sum.
  - `carry` is 1 bit.
  - `cnt` is a bit counter of width ceil(log2(WIDTH+1)).
  - `state` is the FSM register.
- FSM has two states: IDLE and RUN.
- **IDLE:**
  - `busy` = 0.
  - If `start` = 1: load `a_sh`←`a`, `b_sh`←`b`, `carry`←`cin`, `cnt`←0, then go to RUN.
- **RUN:**
  - `busy` = 1.
  - One `full_adder` instance takes inputs `a_sh[0]`, `b_sh[0]` and `carry`, and produces outputs `s` and `c1`.
  - Each edge does the following:
    - `acc` ← {`s`, `acc[WIDTH-1:1]`}, i.e. shift right with the new bit entering at the MSB.
    - `a_sh` and `b_sh` shift right by 1, filling with 0.
    - `carry` ← `c1`.
    - `cnt` ← `cnt`+1.
- **Completion:**
  - On the edge where `cnt` = WIDTH-1, the last bit is processed.
  - On that same edge: `sum` ← final `acc` value (including the bit computed on that edge), `cout` ← `c1`, `done` ← 1, state ← IDLE.
- `done` is a register, cleared on every edge on which it is not set.
- `start` while `busy` = 1 is ignored. The operands in flight are unaffected and no queueing occurs.
- `start` in the same cycle that `done` = 1 is accepted, because the FSM is already in IDLE. This allows back-to-back operations.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, taken modulo 2^(WIDTH+1). Operands are unsigned. No overflow flag is provided; signed users derive overflow externally.
- `sum` and `cout` change only on a completion edge. They stay stable while the next addition is in progress.
- **Reset (`rst_n` = 0, at any time, including mid-RUN):**
  - Immediately: state = IDLE, `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0.
  - Shift registers, `acc`, `carry` and `cnt` are cleared to 0.
  - The aborted operation produces no `done`.
  - After release, the first rising edge with `start` = 1 begins a fresh operation.

## Timing
- Let E0 be the rising edge that samples `start` = 1 in IDLE.
- `busy` is high from just after E0 until just after E0+WIDTH, i.e. for exactly WIDTH cycles.
- Bit i of the result (LSB first) is computed on edge E0+1+i, for i = 0..WIDTH-1.
- On edge E0+WIDTH, `sum`, `cout` and `done` update. `done` = 1 for the cycle between E0+WIDTH and E0+WIDTH+1.
- Latency from start to done is WIDTH cycles. Throughput is one result per WIDTH cycles with back-to-back starts.
- The only combinational path is through the single full-adder cell, so it is independent of WIDTH.
- `busy` and `done` are decoded from registers; neither is a combinational function of `start`.

## Test plan
All scenarios use WIDTH = 8.
- **Reset values:** assert `rst_n` = 0 → `busy`=0, `done`=0, `sum`=0x00, `cout`=0; all hold after release with `start`=0.
- **Basic add:** `a`=0x5A, `b`=0x33, `cin`=0, pulse `start` → `busy` high for 8 cycles; `done` pulses once, 8 edges after the start edge; `sum`=0x8D, `cout`=0.
- **Carry ripple across all bits:**
  - `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1.
  - Then `a`=0xFF, `b`=0x00, `cin`=1 → `sum`=0x00, `cout`=1.
  - Then `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- **Start while busy:** start 0x10+0x20; on the 3rd busy cycle assert `start` with `a`=0xFF, `b`=0xFF → that start is ignored; result is `sum`=0x30, `cout`=0; exactly one `done` pulse.
- **Back-to-back:** assert `start` (0x01+0x02) in the `done` cycle of a previous add (0x80+0x80 → `sum`=0x00, `cout`=1) → the next `done` comes 8 cycles later with `sum`=0x03, `cout`=0; the previous result holds until then.
- **Reset mid-operation:** start 0x55+0xAA, drop `rst_n` after 4 busy cycles → outputs return to reset values at once; no `done` appears; a subsequent 0x01+0x01 → `sum`=0x02.
